instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the five-stage core. Issues in-order word requests to the instruction memory, buffers returned instructions with their PCs in a small queue, and presents the head to the decode stage as instruction/PC/PC+4. Accepts redirects (JAL target) from decode, flushes the queue and discards stale in-flight responses. Holds the head under hazard-unit stall.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset
- FIFO_DEPTH, 4: instruction queue entries (power of two, ≥2)

- i_aclk  in  1  clock
- i_areset_n  in  1  reset, asynchronous, active-low
- i_stall  in  1  hazard unit: hold queue head, do not pop
- i_branch_valid  in  1  decode redirect request
- i_branch_addr  in  INST_SIZE  redirect target
- o_imem_req  out  1  request valid
- o_imem_addr  out  INST_SIZE  word address of request
- i_imem_ready  in  1  memory accepts request this cycle
- i_imem_rvalid  in  1  response valid (in order, ≥1 cycle after accept)
- i_imem_rdata  in  INST_SIZE  response instruction
- o_instruction  out  INST_SIZE  to decode i_instruction
- o_pc  out  INST_SIZE  to decode i_pc
- o_pcplus4  out  INST_SIZE  to decode i_pcplus4
- o_misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- State: fetch_pc, queue (entry = {instr, pc}), outstanding counter (0..FIFO_DEPTH), drop counter (0..FIFO_DEPTH).
- Issue: o_imem_req = !i_branch_valid && (outstanding + count < FIFO_DEPTH) (&& !halted if macro on). o_imem_addr = fetch_pc. Accept (req && ready): fetch_pc += 4, modulo 2^INST_SIZE; outstanding++.
- Response: rvalid decrements outstanding. If drop > 0 or i_branch_valid this cycle: discard, drop-- (if >0). Else push {rdata, pc_tag}; pc_tag is a counter advanced per kept response, loaded with redirect target. Credit rule guarantees no overflow; push on full is a design error (assertion).
- Output: queue non-empty and !i_branch_valid → head instr, head pc, head pc+4. Otherwise o_instruction = NOOP_CODE, o_pc = o_pcplus4 = 0.
- Pop: !empty && !i_stall && !i_branch_valid.
- Redirect (i_branch_valid): at edge, fetch_pc ← i_branch_addr & ~3, pc_tag ← same, queue emptied, drop ← outstanding − i_imem_rvalid. Redirect overrides stall.
- Simultaneous push+pop on non-full queue: count unchanged.

## Timing
- Reset values: fetch_pc = pc_tag = RESET_PC, queue empty, outstanding = drop = 0, o_imem_req = 1 after release, o_instruction = NOOP_CODE, o_pc = o_pcplus4 = 0, o_misaligned = 0.
- Reset mid-operation clears all state; imem shares the reset, so no pre-reset response arrives afterwards.
- Outputs combinational from queue head and i_branch_valid; no register between queue and decode (decode registers).
- 1-cycle memory: request cycle N, rvalid N+1, head visible N+2, decode latches at end of N+2. Redirect to first target visible: 3 cycles after redirect cycle.
- Full throughput (1 instr/cycle) requires FIFO_DEPTH ≥ memory latency + 2.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined: redirect with i_branch_addr[1:0] ≠ 0 sets o_misaligned (sticky until reset), enters halted state: no further requests, queue flushed, outputs NOOP, in-flight responses dropped.
- Undefined: address bits [1:0] masked, o_misaligned tied 0, no halted state.

## Structure
- Shared package: NOOP_CODE, INST_SIZE (existing); add typedef t_fetch_entry {instr, pc}.
- One sub-module: fetch_queue (parameterised FIFO with push/pop/flush, count, head output).

## Test plan
- Reset, 1-cycle memory always ready, imem[0..] = 0x00100093, 0x00200113, … → decode sees pc 0, 4, 8 consecutively from cycle 2, one per cycle, pcplus4 = pc+4.
- i_stall high 3 cycles while head pc=8 → head stays pc=8, no pop; requests stop once outstanding+count=4; resumes pc=8,12 after release.
- i_branch_valid with addr 0x100 while 2 requests outstanding → o_instruction NOOP that cycle, both stale responses dropped, next outputs pc 0x100, 0x104.
- Redirect in same cycle as rvalid and stall → response discarded, drop=outstanding−1, redirect taken.
- i_imem_ready low 5 cycles → o_imem_addr held, outputs NOOP after queue drains, correct pc sequence afterwards.
- Macro on, redirect to 0x102 → o_misaligned=1, no further o_imem_req, NOOP outputs until reset; macro off → fetch resumes at 0x100.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: instruction width,
// the no-op encoding shown to decode when nothing is valid, and the queue entry.
package instr_fetch_pkg;

  localparam int unsigned INST_SIZE = 32;

  // addi x0, x0, 0
  localparam logic [INST_SIZE-1:0] NOOP_CODE = 32'h0000_0013;

  typedef struct packed {
    logic [INST_SIZE-1:0] instr;
    logic [INST_SIZE-1:0] pc;
  } t_fetch_entry;

  // Clear the byte-offset bits of an address to get a word address.
  function automatic logic [INST_SIZE-1:0] word_align(input logic [INST_SIZE-1:0] addr);
    return {addr[INST_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between memory responses and decode.
// Circular FIFO with push/pop/flush, occupancy count and a combinational head.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_aclk,
  input  logic                   i_areset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  t_fetch_entry           i_data,
  output t_fetch_entry           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  t_fetch_entry  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  // Next-state for pointers and count; flush wins over push/pop.
  always_comb begin
    o_empty  = (count_q == '0);
    o_full   = (count_q == FULL_CNT);
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge i_aclk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

  // Upstream credit accounting must never let a response arrive into a full queue.
  assert property (@(posedge i_aclk) disable iff (!i_areset_n) !(i_push && o_full && !i_flush));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: in-order word requests to instruction memory,
// responses buffered with their PCs, head presented to decode.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (misaligned redirect halts fetch).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [INST_SIZE-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_stall,
  input  logic                 i_branch_valid,
  input  logic [INST_SIZE-1:0] i_branch_addr,
  output logic                 o_imem_req,
  output logic [INST_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_ready,
  input  logic                 i_imem_rvalid,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic [INST_SIZE-1:0] o_pc,
  output logic [INST_SIZE-1:0] o_pcplus4,
  output logic                 o_misaligned
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [INST_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_SIZE-1:0] pc_tag_q,   pc_tag_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_q, drop_d;

  logic [INST_SIZE-1:0] redirect_pc;
  logic [CW:0]          credit_used;
  logic                 halted;
  logic                 accept, discard, push, pop, head_valid;
  logic [CW-1:0]        q_count;
  logic                 q_empty, q_full;
  t_fetch_entry         q_head, q_wdata;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  // Sticky misaligned-redirect flag; it doubles as the halted state.
  always_comb begin
    misaligned_d = misaligned_q | (i_branch_valid && (i_branch_addr[1:0] != 2'b00));
  end

  // Misaligned flag register.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) misaligned_q <= 1'b0;
    else             misaligned_q <= misaligned_d;
  end

  assign halted       = misaligned_q;
  assign o_misaligned = misaligned_q;
`else
  assign halted       = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Request issue, response keep/discard and queue control.
  always_comb begin
    redirect_pc = word_align(i_branch_addr);
    credit_used = {1'b0, outstanding_q} + {1'b0, q_count};
    o_imem_req  = !i_branch_valid && !halted && (credit_used < (CW + 1)'(FIFO_DEPTH));
    o_imem_addr = fetch_pc_q;
    accept      = o_imem_req && i_imem_ready;
    discard     = i_imem_rvalid && ((drop_q != '0) || i_branch_valid || halted);
    push        = i_imem_rvalid && !discard;
    pop         = !q_empty && !i_stall && !i_branch_valid && !halted;
    q_wdata     = '{instr: i_imem_rdata, pc: pc_tag_q};
  end

  // Next-state for fetch address, PC tag and in-flight/drop counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pc_tag_d      = pc_tag_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (accept && !i_imem_rvalid)      outstanding_d = outstanding_q + CW'(1);
    else if (!accept && i_imem_rvalid) outstanding_d = outstanding_q - CW'(1);

    if (i_branch_valid) begin
      fetch_pc_d = redirect_pc;
      pc_tag_d   = redirect_pc;
      // Everything still in flight after this edge belongs to the old path.
      drop_d     = outstanding_q - CW'(i_imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   pc_tag_d   = pc_tag_q + 32'd4;
      if (i_imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      fetch_pc_q    <= RESET_PC;
      pc_tag_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pc_tag_q      <= pc_tag_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_push     (push),
    .i_pop      (pop),
    .i_flush    (i_branch_valid),
    .i_data     (q_wdata),
    .o_head     (q_head),
    .o_count    (q_count),
    .o_empty    (q_empty),
    .o_full     (q_full)
  );

  // Decode-facing outputs straight from the queue head; a redirect blanks them.
  always_comb begin
    head_valid    = !q_empty && !i_branch_valid;
    o_instruction = NOOP_CODE;
    o_pc          = '0;
    o_pcplus4     = '0;
    if (head_valid) begin
      o_instruction = q_head.instr;
      o_pc          = q_head.pc;
      o_pcplus4     = q_head.pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// checked against a program-order stream model. Honors IFETCH_MISALIGN_CHECK_EN.
module tb_instr_fetch;

  localparam logic [31:0] NOOP = 32'h0000_0013;

  logic        i_aclk = 1'b0;
  logic        i_areset_n;
  logic        i_stall;
  logic        i_branch_valid;
  logic [31:0] i_branch_addr;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [31:0] o_pcplus4;
  logic        o_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic [31:0] pend[$];
  logic        mem_go;

  // samples taken before each active edge
  logic        s_req, s_mis;
  logic [31:0] s_addr, s_instr, s_pc, s_p4;

  always #5 i_aclk = ~i_aclk;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_aclk         (i_aclk),
    .i_areset_n     (i_areset_n),
    .i_stall        (i_stall),
    .i_branch_valid (i_branch_valid),
    .i_branch_addr  (i_branch_addr),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_ready   (i_imem_ready),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .o_instruction  (o_instruction),
    .o_pc           (o_pc),
    .o_pcplus4      (o_pcplus4),
    .o_misaligned   (o_misaligned)
  );

  // Program image: word n holds "addi x(n+1), x0, n+1".
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) + 32'd1;
    return {w[11:0], 5'd0, 3'd0, w[4:0], 7'h13};
  endfunction

  // One clock cycle: present memory response, sample outputs, advance memory model.
  task automatic tick();
    logic acc;
    if (pend.size() > 0 && mem_go) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = imem(pend[0]);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr; s_instr = o_instruction;
    s_pc = o_pc; s_p4 = o_pcplus4; s_mis = o_misaligned;
    acc = o_imem_req && i_imem_ready;
    @(posedge i_aclk);
    if (i_imem_rvalid) void'(pend.pop_front());
    if (acc) pend.push_back(s_addr);
    @(negedge i_aclk);
  endtask

  task automatic do_reset();
    i_areset_n = 1'b0; i_stall = 1'b0; i_branch_valid = 1'b0; i_branch_addr = '0;
    i_imem_ready = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0; mem_go = 1'b1;
    pend.delete();
    repeat (2) @(negedge i_aclk);
    i_areset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got %b want 1", o_imem_req); end
    n_tests++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", o_imem_addr); end
    n_tests++; if (o_instruction !== NOOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", o_instruction, NOOP); end
    n_tests++; if (o_pc !== 32'h0 || o_pcplus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h/%h want 0/0", o_pc, o_pcplus4); end
    n_tests++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b want 0", o_misaligned); end
    repeat (5) tick();
    // mid-operation reset
    i_areset_n = 1'b0; pend.delete(); i_imem_rvalid = 1'b0;
    #1;
    n_tests++; if (o_instruction !== NOOP || o_pc !== 32'h0) begin n_fail++; $display("FAIL midreset_out got %h/%h want %h/0", o_instruction, o_pc, NOOP); end
    @(negedge i_aclk);
    i_areset_n = 1'b1;
    #1;
    n_tests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_req got %b/%h want 1/0", o_imem_req, o_imem_addr); end
  endtask

  task automatic test_throughput();
    logic [31:0] e;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++; if (s_addr !== 32'(4 * c) || s_req !== 1'b1) begin n_fail++; $display("FAIL thr_addr c%0d got %b/%h want 1/%h", c, s_req, s_addr, 32'(4 * c)); end
      if (c < 2) begin
        n_tests++; if (s_instr !== NOOP) begin n_fail++; $display("FAIL thr_noop c%0d got %h want %h", c, s_instr, NOOP); end
      end else begin
        e = 32'(4 * (c - 2));
        n_tests++; if (s_pc !== e || s_instr !== imem(e) || s_p4 !== e + 32'd4) begin n_fail++; $display("FAIL thr_head c%0d got %h/%h/%h want %h/%h/%h", c, s_pc, s_instr, s_p4, e, imem(e), e + 32'd4); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [12] = '{0, 0, 0, 4, 8, 8, 8, 8, 12, 16, 20, 24};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      i_stall = (c >= 4 && c <= 6);
      tick();
      if (c >= 2) begin
        n_tests++; if (s_pc !== exp_pc[c] || s_instr !== imem(exp_pc[c])) begin n_fail++; $display("FAIL stall_head c%0d got %h/%h want %h", c, s_pc, s_instr, exp_pc[c]); end
      end
      if (c >= 4 && c <= 8) begin
        n_tests++; if (s_req !== !(c == 6 || c == 7)) begin n_fail++; $display("FAIL stall_req c%0d got %b want %b", c, s_req, !(c == 6 || c == 7)); end
      end
      if (c == 8) begin
        n_tests++; if (s_addr !== 32'd24) begin n_fail++; $display("FAIL stall_resume_addr got %h want 18", s_addr); end
      end
    end
    i_stall = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      mem_go         = (c >= 3);
      i_branch_valid = (c == 2);
      i_branch_addr  = 32'h100;
      tick();
      if (c == 2) begin
        n_tests++; if (s_instr !== NOOP || s_pc !== 0 || s_p4 !== 0 || s_req !== 0) begin n_fail++; $display("FAIL redir_cycle got %h/%h/%h req %b want NOOP/0/0 req 0", s_instr, s_pc, s_p4, s_req); end
      end
      if (c == 3) begin
        n_tests++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %b/%h want 1/100", s_req, s_addr); end
      end
      if (c >= 3 && c <= 5) begin
        n_tests++; if (s_instr !== NOOP) begin n_fail++; $display("FAIL redir_drop c%0d got %h/%h want NOOP", c, s_instr, s_pc); end
      end
      if (c >= 6) begin
        n_tests++; if (s_pc !== 32'(32'h100 + 4 * (c - 6)) || s_instr !== imem(s_pc)) begin n_fail++; $display("FAIL redir_head c%0d got %h want %h", c, s_pc, 32'(32'h100 + 4 * (c - 6))); end
      end
    end
    i_branch_valid = 1'b0; mem_go = 1'b1;
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      i_stall        = (c == 4);
      i_branch_valid = (c == 4);
      i_branch_addr  = 32'h200;
      tick();
      if (c == 4) begin
        n_tests++; if (s_instr !== NOOP || s_pc !== 0 || s_req !== 0) begin n_fail++; $display("FAIL rsr_cycle got %h/%h req %b want NOOP/0 req 0", s_instr, s_pc, s_req); end
      end
      if (c == 5) begin
        n_tests++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin n_fail++; $display("FAIL rsr_addr got %b/%h want 1/200", s_req, s_addr); end
      end
      if (c == 5 || c == 6) begin
        n_tests++; if (s_instr !== NOOP) begin n_fail++; $display("FAIL rsr_noop c%0d got %h want NOOP", c, s_instr); end
      end
      if (c >= 7) begin
        n_tests++; if (s_pc !== 32'(32'h200 + 4 * (c - 7)) || s_instr !== imem(s_pc)) begin n_fail++; $display("FAIL rsr_head c%0d got %h want %h", c, s_pc, 32'(32'h200 + 4 * (c - 7))); end
      end
    end
    i_stall = 1'b0; i_branch_valid = 1'b0;
  endtask

  task automatic test_ready_low();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      i_imem_ready = !(c >= 4 && c <= 8);
      tick();
      if (c >= 4 && c <= 9) begin
        n_tests++; if (s_addr !== 32'd16) begin n_fail++; $display("FAIL rdy_hold c%0d got %h want 10", c, s_addr); end
      end
      if (c >= 6 && c <= 10) begin
        n_tests++; if (s_instr !== NOOP || s_pc !== 0) begin n_fail++; $display("FAIL rdy_drain c%0d got %h/%h want NOOP/0", c, s_instr, s_pc); end
      end
      if (c == 4 || c == 5 || c >= 11) begin
        n_tests++; if (s_pc !== (c >= 11 ? 32'(16 + 4 * (c - 11)) : 32'(8 + 4 * (c - 4)))) begin n_fail++; $display("FAIL rdy_head c%0d got %h", c, s_pc); end
      end
    end
    i_imem_ready = 1'b1;
  endtask

  task automatic test_misalign();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      i_branch_valid = (c == 4);
      i_branch_addr  = 32'h102;
      tick();
      if (c == 4) begin
        n_tests++; if (s_mis !== 1'b0) begin n_fail++; $display("FAIL mis_early got %b want 0", s_mis); end
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (c >= 5) begin
        n_tests++; if (s_mis !== 1'b1 || s_req !== 1'b0 || s_instr !== NOOP) begin n_fail++; $display("FAIL mis_halt c%0d got mis %b req %b instr %h want 1/0/NOOP", c, s_mis, s_req, s_instr); end
      end
`else
      if (c >= 5) begin
        n_tests++; if (s_mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag c%0d got %b want 0", c, s_mis); end
      end
      if (c == 7 || c == 8) begin
        n_tests++; if (s_pc !== 32'(32'h100 + 4 * (c - 7)) || s_instr !== imem(s_pc)) begin n_fail++; $display("FAIL mis_resume c%0d got %h want %h", c, s_pc, 32'(32'h100 + 4 * (c - 7))); end
      end
`endif
    end
    i_branch_valid = 1'b0;
    do_reset();
    #1;
    n_tests++; if (o_misaligned !== 1'b0 || o_imem_req !== 1'b1) begin n_fail++; $display("FAIL mis_reset got mis %b req %b want 0/1", o_misaligned, o_imem_req); end
  endtask

  // Random traffic: decode must see the program-order stream from each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, exp_fetch;
    logic        st, br;
    logic [31:0] ba;
    int          consumed;
    do_reset();
    exp_pc = 0; exp_fetch = 0; consumed = 0;
    for (int c = 0; c < 600; c++) begin
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 19) == 0);
      ba = 32'($urandom_range(0, 32'h3C0)) << 2;
      i_stall = st; i_branch_valid = br; i_branch_addr = ba;
      i_imem_ready = ($urandom_range(0, 9) < 7);
      mem_go = ($urandom_range(0, 9) < 7);
      tick();
      if (br) begin
        n_tests++; if (s_instr !== NOOP || s_pc !== 0 || s_p4 !== 0 || s_req !== 0) begin n_fail++; $display("FAIL rnd_redir c%0d got %h/%h/%h req %b", c, s_instr, s_pc, s_p4, s_req); end
        exp_pc = ba; exp_fetch = ba;
      end else begin
        if (s_req && i_imem_ready) begin
          n_tests++; if (s_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_fetch c%0d got %h want %h", c, s_addr, exp_fetch); end
          exp_fetch = exp_fetch + 32'd4;
        end
        if (s_instr !== NOOP) begin
          n_tests++; if (s_pc !== exp_pc || s_instr !== imem(exp_pc) || s_p4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rnd_head c%0d got %h/%h/%h want %h/%h", c, s_pc, s_instr, s_p4, exp_pc, imem(exp_pc)); end
          if (!st) begin exp_pc = exp_pc + 32'd4; consumed++; end
        end else begin
          n_tests++; if (s_pc !== 0 || s_p4 !== 0) begin n_fail++; $display("FAIL rnd_idle c%0d got %h/%h want 0/0", c, s_pc, s_p4); end
        end
      end
      n_tests++; if (pend.size() > 4) begin n_fail++; $display("FAIL rnd_credit c%0d got %0d outstanding want <=4", c, pend.size()); end
    end
    n_tests++; if (consumed < 100) begin n_fail++; $display("FAIL rnd_progress got %0d instructions want >=100", consumed); end
    i_stall = 1'b0; i_branch_valid = 1'b0; i_imem_ready = 1'b1; mem_go = 1'b1;
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_stall();
    test_redirect();
    test_redirect_rvalid_stall();
    test_ready_low();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
